// File: rtl/cpu_pkg.sv
// Shared CPU types: memory-port grant owner, arbiter FSM states, datapath width.
package cpu_pkg;

  localparam int XLEN = 32;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_D  = 1'b1
  } grant_t;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of the unified memory port between fetch and load/store,
// sequencing each access through a fixed-latency memory with a registered ready pulse.
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_ready,
  output logic [XLEN-1:0] if_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [XLEN-1:0] d_addr,
  input  logic [XLEN-1:0] d_wdata,
  output logic            d_ready,
  output logic [XLEN-1:0] d_rdata,
  output logic            mem_en,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            mem_sel
);

  localparam int CW = $clog2(LAT + 1);
  localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

  arb_state_t      state, state_d;
  logic [CW-1:0]   cnt, cnt_d;
  grant_t          last_grant, pick;
  logic            grant, capture;
  logic [XLEN-1:0] rdata_q;

  assign if_rdata = rdata_q;
  assign d_rdata  = rdata_q;

  // DONE never grants: the completing requester still holds req this cycle.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    pick    = GNT_IF;
    grant   = 1'b0;
    capture = 1'b0;
    case (state)
      IDLE: begin
        if (if_req || d_req) begin
          grant   = 1'b1;
          if (if_req && d_req) pick = (last_grant == GNT_IF) ? GNT_D : GNT_IF;
          else                 pick = d_req ? GNT_D : GNT_IF;
          state_d = BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt == '0) begin
          capture = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      last_grant <= GNT_IF;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_sel    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rdata_q    <= '0;
      if_ready   <= 1'b0;
      d_ready    <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      mem_en   <= (state_d == BUSY);
      if_ready <= capture && (mem_sel == GNT_IF);
      d_ready  <= capture && (mem_sel == GNT_D);
      if (grant) begin
        last_grant <= pick;
        mem_sel    <= pick;
        mem_addr   <= (pick == GNT_D) ? d_addr : if_addr;
        mem_wdata  <= (pick == GNT_D) ? d_wdata : '0;
        mem_we     <= (pick == GNT_D) && d_we;
      end
      if (capture) rdata_q <= mem_rdata;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the CPU's single unified memory port between the instruction-fetch unit and the load/store unit. It performs two jobs:
- Arbitrates with a round-robin policy.
- Sequences each access through a fixed-latency memory, driving the 2:1 address-select line and returning read data with a one-cycle ready pulse.

It sits between the fetch/LSU stages and the memory macro.

## Interface
- LAT, 2: memory read latency in cycles from first mem_en cycle to valid mem_rdata; legal range 1..15.
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request, level, held until if_ready.
- if_addr  in  32  fetch address.
- if_ready  out  1  one-cycle completion pulse to fetch.
- if_rdata  out  32  fetch read data, valid while if_ready.
- d_req  in  1  load/store request, level, held until d_ready.
- d_we  in  1  1 = store.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_ready  out  1  one-cycle completion pulse to LSU.
- d_rdata  out  32  load data, valid while d_ready.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data.
- mem_sel  out  1  address-mux select: 0 = fetch, 1 = data.

## Operation
States:
- IDLE: if any request is present, latch the grant, address, wdata and we, then go to BUSY with cnt = LAT-1.
- BUSY: mem_en = 1. If cnt == 0, capture mem_rdata into rdata_q and go to DONE; otherwise decrement cnt.
- DONE: pulse the granted ready for one cycle, then go to IDLE unconditionally. DONE never re-grants, because the completing requester's req is still high in this cycle.

Grant rules:
- Only one request present: grant it.
- Both present: grant the requester that did not win last. last_grant resets to fetch, so the first conflict after reset goes to data.
- last_grant updates at every grant.

Output and data rules:
- mem_addr, mem_wdata, mem_we and mem_sel come from the latched registers and are stable for the whole BUSY period.
- mem_we = granted-data AND latched d_we; it is forced to 0 on fetch grants.
- if_rdata and d_rdata both drive rdata_q. Each is meaningful only while its own ready is high.
- A store still captures rdata_q, and d_ready pulses as for a load.
- A request that drops during BUSY is a protocol violation. The transaction still completes and ready still pulses.
- A request arriving during BUSY or DONE waits until IDLE; it is never lost while held.

Reset:
- Asynchronous. Clears state to IDLE, cnt to 0, last_grant to fetch.
- Reset values are 0 for mem_en, mem_we, mem_sel, mem_addr, mem_wdata, rdata_q, if_ready and d_ready.
- An in-flight transaction is dropped with no ready pulse; the requester must reissue.

## Timing
- Request sampled at rising edge n: mem_en is high for the cycles following edges n .. n+LAT-1.
- mem_rdata is sampled at edge n+LAT.
- Ready is high between edges n+LAT and n+LAT+1.
- Request-to-ready latency is LAT+1 cycles.
- Minimum spacing between grants is LAT+2 cycles (IDLE→BUSY×LAT→DONE→IDLE).
- All outputs are registered; there is no combinational path from req to mem_* or to ready.

## Structure
- Shared package cpu_pkg:
  - grant_t enum: GNT_IF = 0, GNT_D = 1.
  - arb_state_t enum: IDLE, BUSY, DONE.
  - width constant XLEN = 32.
- cnt width is $clog2(LAT+1), sized from the parameter locally.
- Single module, no sub-modules. The 2:1 selection is a registered latch in the grant logic.

## Test plan
All with LAT = 2.
- Reset: with rst_n = 0, all outputs read 0. After release with no requests, mem_en stays 0 for 10 cycles.
- Single fetch: if_req = 1, if_addr = 0x100, memory returns 0xDEADBEEF.
  - mem_sel = 0, mem_addr = 0x100.
  - mem_en high for 2 cycles.
  - if_ready pulses 3 cycles after sampling, with if_rdata = 0xDEADBEEF.
- Store: d_req = 1, d_we = 1, d_addr = 0x2000, d_wdata = 0x12345678.
  - mem_we = 1, mem_sel = 1, mem_wdata = 0x12345678 for 2 cycles.
  - d_ready pulses once.
- Conflict round-robin: hold both requests continuously after reset.
  - Grant order is D, IF, D, IF.
  - Grants are spaced 4 cycles apart.
  - Each ready pulses exactly once per grant.
- Reset mid-BUSY: assert rst_n = 0 during BUSY.
  - Outputs go to 0 immediately, with no ready pulse.
  - After release with the request still held, the transaction restarts and completes in 3 cycles.
- Request during DONE: raise if_req while d_ready is pulsing.
  - The fetch is granted the cycle after DONE.
  - The data requester is not granted twice.
